lin_norm_sequencer: RTL and testbench

Sequencer for the `LINEALIZADOR_NORMALIZADOR` datapath. It accepts paired current/voltage samples (I, V) on a valid/ready input handshake and drives them into the datapath. It then issues the `Begin_FSM_I`/`Begin_FSM_V` start pulses and collects the independently arriving `ACK_I`/`ACK_V` results. It returns the paired results on a valid/ready output handshake, and pulses the datapath FSM reset between samples. A timeout guards against a datapath that never acknowledges.

---
 rtl/lin_norm_pkg.sv | 23 ++
 rtl/ln_timeout_counter.sv | 30 +++
 rtl/lin_norm_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_lin_norm_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lin_norm_pkg.sv
// Shared types and constants for the LINEALIZADOR_NORMALIZADOR sequencer.
package lin_norm_pkg;

   // Sequencer states; encodings are fixed so waveforms and debug probes stay comparable.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_OUT   = 3'd4,
      ST_CLEAR = 3'd5
   } ln_state_e;

   localparam int DEFAULT_TIMEOUT    = 2000;
   localparam int DEFAULT_CLR_CYCLES = 1;
   localparam int DEFAULT_CNT_W      = 16;

   // Bits needed to hold values 0..max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ln_timeout_counter.sv
// Loadable down-counter with a zero flag. The sequencer reuses it for the WAIT
// timeout and for the CLEAR hold count, which never overlap in time.
module ln_timeout_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // Load wins over decrement; the count parks at zero instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: registers are updated with <= so every flop samples pre-edge values, independent of statement order.
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lin_norm_sequencer.sv
// Sequencer for the LINEALIZADOR_NORMALIZADOR datapath: accepts an (I, V) sample
// pair, starts both datapath FSMs, collects the two independent ACKs (with a
// timeout), returns the paired results and pulses the datapath FSM reset.
module lin_norm_sequencer #(
   parameter int P          = 32,
   parameter int TIMEOUT    = lin_norm_pkg::DEFAULT_TIMEOUT,
   parameter int CLR_CYCLES = lin_norm_pkg::DEFAULT_CLR_CYCLES,
   parameter int CNT_W      = lin_norm_pkg::DEFAULT_CNT_W
) (
   input  logic             CLK,
   input  logic             RST_N,
   // sample input handshake
   input  logic [P-1:0]     IN_I,
   input  logic [P-1:0]     IN_V,
   input  logic             IN_VALID,
   output logic             IN_READY,
   // datapath side
   output logic [P-1:0]     I,
   output logic [P-1:0]     V,
   output logic             Begin_FSM_I,
   output logic             Begin_FSM_V,
   output logic             RST_FSM_LN_FF,
   input  logic             ACK_I,
   input  logic             ACK_V,
   input  logic [P-1:0]     RESULT_I,
   input  logic [P-1:0]     RESULT_V,
   // result output handshake
   output logic [P-1:0]     OUT_I,
   output logic [P-1:0]     OUT_V,
   output logic             OUT_ERR,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   // statistics
   output logic [CNT_W-1:0] SAMPLE_CNT,
   output logic [7:0]       TIMEOUT_CNT
);

   import lin_norm_pkg::*;

   // One shared counter covers both the WAIT budget and the CLEAR hold.
   localparam int TMR_MAX = ((TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES) - 1;
   localparam int TW      = cnt_width(TMR_MAX);

   ln_state_e        state_q;
   logic [P-1:0]     i_q, v_q;
   logic             begin_q;
   logic             clear_q;
   logic             got_i_q, got_v_q;
   logic [P-1:0]     out_i_q, out_v_q;
   logic             out_err_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] sample_cnt_q;
   logic [7:0]       timeout_cnt_q;

   logic             tmr_load_d;
   logic [TW-1:0]    tmr_val_d;
   logic             tmr_dec_d;
   logic             tmr_zero;

   logic             cap_i, cap_v, both_done;

   // A channel is captured on its first ACK in WAIT; "done" includes this cycle's capture.
   assign cap_i     = ACK_I & ~got_i_q;
   assign cap_v     = ACK_V & ~got_v_q;
   assign both_done = (got_i_q | ACK_I) & (got_v_q | ACK_V);

   // Timer control: arm the WAIT budget in START, arm the CLEAR hold on output acceptance.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case can infer a latch.
      tmr_load_d = 1'b0;
      tmr_val_d  = '0;
      tmr_dec_d  = 1'b0;
      case (state_q)
         ST_START: begin
            tmr_load_d = 1'b1;
            tmr_val_d  = TW'(TIMEOUT - 1);
         end
         ST_WAIT:  tmr_dec_d = ~both_done;
         ST_OUT: begin
            tmr_load_d = OUT_READY;
            tmr_val_d  = TW'(CLR_CYCLES - 1);
         end
         ST_CLEAR: tmr_dec_d = 1'b1;
         default:  ;
      endcase
   end

   ln_timeout_counter #(
      .W (TW)
   ) u_timer (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .load_i     (tmr_load_d),
      .load_val_i (tmr_val_d),
      .dec_i      (tmr_dec_d),
      .zero_o     (tmr_zero)
   );

   // Main sequencer FSM with all datapath-facing and result outputs registered.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: operand and result registers are reset as well because they drive outputs directly.
         state_q       <= ST_IDLE;
         i_q           <= '0;
         v_q           <= '0;
         begin_q       <= 1'b0;
         clear_q       <= 1'b0;
         got_i_q       <= 1'b0;
         got_v_q       <= 1'b0;
         out_i_q       <= '0;
         out_v_q       <= '0;
         out_err_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         sample_cnt_q  <= '0;
         timeout_cnt_q <= '0;
      end else begin
         begin_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (IN_VALID) begin
                  i_q     <= IN_I;
                  v_q     <= IN_V;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               begin_q <= 1'b1;
               state_q <= ST_START;
            end
            ST_START: begin
               got_i_q   <= 1'b0;
               got_v_q   <= 1'b0;
               out_i_q   <= '0;
               out_v_q   <= '0;
               out_err_q <= 1'b0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cap_i) begin
                  got_i_q <= 1'b1;
                  out_i_q <= RESULT_I;
               end
               if (cap_v) begin
                  got_v_q <= 1'b1;
                  out_v_q <= RESULT_V;
               end
               if (both_done) begin
                  out_err_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end else if (tmr_zero) begin
                  out_err_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (OUT_READY) begin
                  out_valid_q  <= 1'b0;
                  sample_cnt_q <= sample_cnt_q + 1'b1;
                  if (out_err_q && (timeout_cnt_q != 8'hFF)) begin
                     timeout_cnt_q <= timeout_cnt_q + 8'd1;
                  end
                  clear_q <= 1'b1;
                  state_q <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (tmr_zero) begin
                  clear_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               clear_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // The datapath is held in reset both during CLEAR and for as long as RST_N is low.
   assign RST_FSM_LN_FF = clear_q | ~RST_N;
   assign IN_READY      = (state_q == ST_IDLE);
   assign I             = i_q;
   assign V             = v_q;
   assign Begin_FSM_I   = begin_q;
   assign Begin_FSM_V   = begin_q;
   assign OUT_I         = out_i_q;
   assign OUT_V         = out_v_q;
   assign OUT_ERR       = out_err_q;
   assign OUT_VALID     = out_valid_q;
   assign SAMPLE_CNT    = sample_cnt_q;
   assign TIMEOUT_CNT   = timeout_cnt_q;

endmodule

// File: tb/tb_lin_norm_sequencer.sv
// Directed bench for lin_norm_sequencer: the bench plays the datapath, driving
// ACKs at chosen WAIT-cycle offsets, and computes every expected result itself.
module tb_lin_norm_sequencer;

   localparam int P   = 32;
   localparam int T   = 32;
   localparam int CLR = 1;
   localparam int CW  = 16;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [P-1:0]  IN_I = '0, IN_V = '0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [P-1:0]  I, V;
   logic          Begin_FSM_I, Begin_FSM_V, RST_FSM_LN_FF;
   logic          ACK_I = 1'b0, ACK_V = 1'b0;
   logic [P-1:0]  RESULT_I = '0, RESULT_V = '0;
   logic [P-1:0]  OUT_I, OUT_V;
   logic          OUT_ERR, OUT_VALID;
   logic          OUT_READY = 1'b0;
   logic [CW-1:0] SAMPLE_CNT;
   logic [7:0]    TIMEOUT_CNT;

   int            n_checks = 0;
   int            n_fail = 0;
   int            exp_samples = 0;
   int            exp_timeouts = 0;
   logic [31:0]   exp_i, exp_v;
   bit            exp_err;

   lin_norm_sequencer #(
      .P (P), .TIMEOUT (T), .CLR_CYCLES (CLR), .CNT_W (CW)
   ) dut (
      .CLK (CLK), .RST_N (RST_N),
      .IN_I (IN_I), .IN_V (IN_V), .IN_VALID (IN_VALID), .IN_READY (IN_READY),
      .I (I), .V (V), .Begin_FSM_I (Begin_FSM_I), .Begin_FSM_V (Begin_FSM_V),
      .RST_FSM_LN_FF (RST_FSM_LN_FF),
      .ACK_I (ACK_I), .ACK_V (ACK_V), .RESULT_I (RESULT_I), .RESULT_V (RESULT_V),
      .OUT_I (OUT_I), .OUT_V (OUT_V), .OUT_ERR (OUT_ERR), .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY), .SAMPLE_CNT (SAMPLE_CNT), .TIMEOUT_CNT (TIMEOUT_CNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hand over one pair and walk it through LOAD and START; returns at WAIT+0.
   task automatic send(input logic [31:0] pi, input logic [31:0] pv, input bit early_ack);
      int guard = 0;
      while (!IN_READY && guard < 100) begin
         tick();
         guard++;
      end
      check("in_ready_idle", IN_READY, 1);
      IN_I = pi;
      IN_V = pv;
      IN_VALID = 1'b1;
      tick();                                   // cycle 1: LOAD
      IN_VALID = 1'b0;
      IN_I = $urandom;
      IN_V = $urandom;
      check("load_ready_low", IN_READY, 0);
      check("load_no_begin", {Begin_FSM_I, Begin_FSM_V}, 0);
      if (early_ack) begin
         ACK_I = 1'b1;
         ACK_V = 1'b1;
         RESULT_I = 32'hDEADBEEF;
         RESULT_V = 32'hBAD0BAD0;
      end
      tick();                                   // cycle 2: START
      check("begin_pulse", {Begin_FSM_I, Begin_FSM_V}, 2'b11);
      check("operand_i", I, pi);
      check("operand_v", V, pv);
      ACK_I = 1'b0;
      ACK_V = 1'b0;
      tick();                                   // cycle 3: WAIT+0
      check("begin_single", {Begin_FSM_I, Begin_FSM_V}, 0);
   endtask

   // Drive ACKs at WAIT offsets di/dv (-1 = never) and check the produced result.
   task automatic wait_out(input logic [31:0] ri, input logic [31:0] rv, input int di, input int dv);
      bit hit_i, hit_v;
      int kend;
      hit_i   = (di >= 0) && (di < T);
      hit_v   = (dv >= 0) && (dv < T);
      exp_err = !(hit_i && hit_v);
      exp_i   = hit_i ? ri : 32'h0;
      exp_v   = hit_v ? rv : 32'h0;
      kend    = exp_err ? T - 1 : ((di > dv) ? di : dv);
      for (int k = 0; k <= kend; k++) begin
         if (k == di) begin
            ACK_I = 1'b1;
            RESULT_I = ri;
         end else if (di >= 0 && k > di) begin
            ACK_I = ((k - di) % 3) != 1;        // drop and re-assert with junk data
            RESULT_I = $urandom;
         end
         if (k == dv) begin
            ACK_V = 1'b1;
            RESULT_V = rv;
         end else if (dv >= 0 && k > dv) begin
            ACK_V = ((k - dv) % 3) != 1;
            RESULT_V = $urandom;
         end
         if (k == kend) check("valid_low_in_wait", OUT_VALID, 0);
         tick();
      end
      check("out_valid", OUT_VALID, 1);
      check("out_i", OUT_I, exp_i);
      check("out_v", OUT_V, exp_v);
      check("out_err", OUT_ERR, exp_err);
   endtask

   // Hold the result for 'hold' cycles, accept it, then walk CLEAR back to IDLE.
   task automatic finish_pair(input int hold);
      for (int h = 0; h < hold; h++) begin
         RESULT_I = $urandom;
         RESULT_V = $urandom;
         ACK_I = $urandom_range(0, 1);
         ACK_V = $urandom_range(0, 1);
         tick();
         check("bp_valid", OUT_VALID, 1);
         check("bp_out_i", OUT_I, exp_i);
         check("bp_out_v", OUT_V, exp_v);
         check("bp_out_err", OUT_ERR, exp_err);
         check("bp_in_ready", IN_READY, 0);
         check("bp_no_clear", RST_FSM_LN_FF, 0);
      end
      OUT_READY = 1'b1;
      tick();                                   // first CLEAR cycle
      OUT_READY = 1'b0;
      ACK_I = 1'b0;
      ACK_V = 1'b0;
      exp_samples = (exp_samples + 1) % (1 << CW);
      if (exp_err && exp_timeouts < 255) exp_timeouts++;
      check("clear_pulse", RST_FSM_LN_FF, 1);
      check("clear_valid_low", OUT_VALID, 0);
      check("sample_cnt", SAMPLE_CNT, exp_samples);
      check("timeout_cnt", TIMEOUT_CNT, exp_timeouts);
      for (int c = 1; c < CLR; c++) begin
         tick();
         check("clear_hold", RST_FSM_LN_FF, 1);
      end
      tick();                                   // back in IDLE
      check("clear_end", RST_FSM_LN_FF, 0);
      check("idle_ready", IN_READY, 1);
   endtask

   initial begin
      logic [31:0] ri, rv, pi, pv;
      int di, dv;

      // Reset state
      #2;
      check("rst_in_ready", IN_READY, 1);
      check("rst_fsm_reset", RST_FSM_LN_FF, 1);
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_begin", {Begin_FSM_I, Begin_FSM_V}, 0);
      check("rst_out_i", OUT_I, 0);
      check("rst_sample_cnt", SAMPLE_CNT, 0);
      check("rst_timeout_cnt", TIMEOUT_CNT, 0);
      repeat (3) tick();
      RST_N = 1'b1;
      tick();
      check("rst_release_fsm", RST_FSM_LN_FF, 0);

      // Nominal pair
      send(32'h3F800000, 32'h40000000, 1'b0);
      wait_out(32'h3E800000, 32'h3F000000, 10, 25);
      finish_pair(0);
      check("operand_hold_i", I, 32'h3F800000);
      check("operand_hold_v", V, 32'h40000000);

      // Simultaneous ACKs, with spurious ACKs driven during LOAD
      send(32'h11111111, 32'h22222222, 1'b1);
      wait_out(32'hA5A5A5A5, 32'h5A5A5A5A, 7, 7);
      finish_pair(0);

      // Timeout: only V answers
      send(32'h01010101, 32'h02020202, 1'b0);
      wait_out(32'hFFFFFFFF, 32'h12345678, -1, 5);
      finish_pair(0);

      // ACK_I lands in the expiry cycle: no error
      send(32'h03030303, 32'h04040404, 1'b0);
      wait_out(32'hCAFEF00D, 32'h0BADF00D, T - 1, 0);
      finish_pair(0);

      // ACK_V alone at WAIT+0, I never: error with V captured
      send(32'h05050505, 32'h06060606, 1'b0);
      wait_out(32'h0, 32'h77777777, -1, 0);
      finish_pair(0);

      // Backpressure
      send(32'h0A0A0A0A, 32'h0B0B0B0B, 1'b0);
      wait_out(32'h13579BDF, 32'h2468ACE0, 2, 4);
      finish_pair(50);

      // Reset in the middle of WAIT
      send(32'h0C0C0C0C, 32'h0D0D0D0D, 1'b0);
      ACK_I = 1'b1;
      RESULT_I = 32'h99999999;
      repeat (4) tick();
      RST_N = 1'b0;
      #1;
      check("mid_rst_ready", IN_READY, 1);
      check("mid_rst_fsm", RST_FSM_LN_FF, 1);
      check("mid_rst_valid", OUT_VALID, 0);
      check("mid_rst_out_i", OUT_I, 0);
      check("mid_rst_sample_cnt", SAMPLE_CNT, 0);
      check("mid_rst_timeout_cnt", TIMEOUT_CNT, 0);
      repeat (3) tick();
      check("mid_rst_fsm_held", RST_FSM_LN_FF, 1);
      ACK_I = 1'b0;
      RST_N = 1'b1;
      #1;
      check("mid_rst_release", RST_FSM_LN_FF, 0);
      exp_samples = 0;
      exp_timeouts = 0;
      send(32'h3F800000, 32'h40400000, 1'b0);
      wait_out(32'h3E000000, 32'h3E400000, 3, 1);
      finish_pair(0);

      // Random pairs that always complete
      for (int n = 0; n < 200; n++) begin
         pi = $urandom;
         pv = $urandom;
         ri = $urandom;
         rv = $urandom;
         di = $urandom_range(0, T - 1);
         dv = $urandom_range(0, T - 1);
         send(pi, pv, 1'b0);
         wait_out(ri, rv, di, dv);
         finish_pair($urandom_range(0, 3));
      end

      // Forced timeouts, enough to saturate TIMEOUT_CNT
      for (int n = 0; n < 260; n++) begin
         rv = $urandom;
         dv = (n % 2 == 0) ? -1 : $urandom_range(0, T - 1);
         send($urandom, $urandom, 1'b0);
         wait_out(32'h0, rv, -1, dv);
         finish_pair(0);
      end
      check("timeout_saturated", TIMEOUT_CNT, 255);
      check("sample_total", SAMPLE_CNT, 461);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
